// File: rtl/storec_writeback_pkg.sv
// Shared definitions for the STOREC writeback path: FSM state encoding,
// error bit positions and default geometry reused from the array codebase.
package storec_writeback_pkg;

   // Codebase-wide widths reused by this block.
   localparam int ADDR_WIDTH         = 64;
   localparam int SARRAY_STORE_WIDTH = 512;
   localparam int TMMA_CNT_WIDTH     = 6;

   // Default row geometry of the writeback buffer.
   localparam int DEFAULT_ROW_SHIFT  = 8;
   localparam int DEFAULT_FIFO_DEPTH = 8;

   // Sticky error register layout.
   localparam int ERR_W        = 2;
   localparam int ERR_OVERFLOW = 0;  // row dropped because the buffer was full
   localparam int ERR_STRAY    = 1;  // row arrived while no STOREC was draining

   // Operation phases of the writeback controller.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } wb_state_t;

endpackage

// File: rtl/storec_writeback_row_fifo.sv
// storec_row_fifo: synchronous row buffer for the STOREC writeback path.
// Pointers carry one extra wrap bit so full and empty are distinguished by
// comparing the MSBs. A pop in the same cycle as a push frees the slot the
// push needs, so a full buffer still accepts a row when it is also draining.
module storec_row_fifo #(
   parameter int WIDTH = 518,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr[PTR_W-1:0]];

   // Pointer update; reset discards any buffered rows.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write; contents are don't-care until the pointers cover them.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[PTR_W-1:0]] <= wdata;
   end

endmodule

// File: rtl/storec_writeback.sv
// storec_writeback: captures the systolic array's bottom-edge rows during a
// STOREC and writes each one to memory at base + (cnt << ROW_SHIFT).
//
// Optional build macro: STOREC_WB_BYPASS_EN. When defined, a row arriving
// while draining with an empty buffer is offered on aw in the same cycle;
// when undefined, rows always pass through the buffer (1-cycle latency).
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. cmd: cmd_ready_o is high only in IDLE; the issuer holds the
// command until accepted. aw: once aw_valid_o rises it stays high with
// address and data unchanged until aw_ready_i completes the beat. The bottom
// row input has no ready; rows that do not fit are dropped and flagged.
module storec_writeback
   import storec_writeback_pkg::*;
#(
   parameter int ADDR_W     = ADDR_WIDTH,
   parameter int DATA_W     = SARRAY_STORE_WIDTH,
   parameter int CNT_W      = TMMA_CNT_WIDTH,
   parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
   parameter int ROW_SHIFT  = DEFAULT_ROW_SHIFT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic              bot_valid_i,
   input  logic [CNT_W-1:0]  bot_cnt_i,
   input  logic [DATA_W-1:0] bot_data_i,
   output logic              aw_valid_o,
   input  logic              aw_ready_i,
   output logic [ADDR_W-1:0] aw_addr_o,
   output logic [DATA_W-1:0] aw_data_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ERR_W-1:0]  err_o
);

   localparam int ENTRY_W = CNT_W + DATA_W;
   // A STOREC always carries exactly 2^CNT_W rows.
   localparam logic [CNT_W:0] ROWS_TOTAL = {1'b1, {CNT_W{1'b0}}};

   wb_state_t          state;
   logic [ADDR_W-1:0]  base;
   logic [CNT_W:0]     rx_cnt;
   logic [ERR_W-1:0]   err;

   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_rdata;
   logic [CNT_W-1:0]   head_cnt;
   logic [DATA_W-1:0]  head_data;

   logic               in_drain;
   logic               row_in;
   logic               bypass_beat;
   logic               aw_fire;
   logic               row_drop;
   logic               drain_complete;
   logic [CNT_W-1:0]   sel_cnt;
   logic [DATA_W-1:0]  sel_data;

   assign in_drain = (state == ST_DRAIN);
   assign row_in   = in_drain & bot_valid_i;
   assign {head_cnt, head_data} = fifo_rdata;

`ifdef STOREC_WB_BYPASS_EN
   // An empty buffer lets the arriving row drive aw directly this cycle.
   assign bypass_beat = row_in & fifo_empty;
   assign sel_cnt     = bypass_beat ? bot_cnt_i  : head_cnt;
   assign sel_data    = bypass_beat ? bot_data_i : head_data;
`else
   // aw is driven only from buffered rows, so it depends on registers alone.
   assign bypass_beat = 1'b0;
   assign sel_cnt     = head_cnt;
   assign sel_data    = head_data;
`endif

   // The address comes from the row's own index, so rows may arrive in any
   // order; the add wraps modulo 2^ADDR_W.
   assign aw_valid_o = ~fifo_empty | bypass_beat;
   assign aw_addr_o  = base + (ADDR_W'(sel_cnt) << ROW_SHIFT);
   assign aw_data_o  = sel_data;
   assign aw_fire    = aw_valid_o & aw_ready_i;

   // A bypassed row that is accepted immediately never enters the buffer;
   // one that stalls is pushed so the buffer head keeps presenting it.
   assign fifo_pop  = aw_fire & ~fifo_empty;
   assign fifo_push = row_in & ~(bypass_beat & aw_ready_i);
   assign row_drop  = fifo_push & fifo_full & ~fifo_pop;

   assign drain_complete = (rx_cnt == ROWS_TOTAL) & fifo_empty;
   assign err_o          = err;

   storec_row_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_row_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata ({bot_cnt_i, bot_data_i}),
      .pop   (fifo_pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Operation sequencing with registered cmd_ready/busy/done and sticky errors.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         base        <= '0;
         rx_cnt      <= '0;
         err         <= '0;
         cmd_ready_o <= 1'b1;
         busy_o      <= 1'b0;
         done_o      <= 1'b0;
      end else begin
         done_o <= 1'b0;
         // Rows outside DRAIN are discarded but remembered.
         if (bot_valid_i && !in_drain) err[ERR_STRAY] <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i && cmd_ready_o) begin
                  base        <= cmd_addr_i;
                  rx_cnt      <= '0;
                  err         <= '0;
                  state       <= ST_DRAIN;
                  cmd_ready_o <= 1'b0;
                  busy_o      <= 1'b1;
               end
            end
            ST_DRAIN: begin
               // Dropped rows still count so the operation always finishes.
               if (bot_valid_i) rx_cnt <= rx_cnt + 1'b1;
               if (row_drop) err[ERR_OVERFLOW] <= 1'b1;
               if (drain_complete) begin
                  state  <= ST_DONE;
                  done_o <= 1'b1;
               end
            end
            ST_DONE: begin
               state       <= ST_IDLE;
               cmd_ready_o <= 1'b1;
               busy_o      <= 1'b0;
            end
            default: begin
               state       <= ST_IDLE;
               cmd_ready_o <= 1'b1;
               busy_o      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_storec_writeback.sv
// Self-checking bench for storec_writeback: directed scenarios plus
// randomized STOREC operations, checked every cycle against a queue model.
module tb_storec_writeback;
   import storec_writeback_pkg::*;

   localparam int ADDR_W  = 64;
   localparam int DATA_W  = 512;
   localparam int CNT_W   = 6;
   localparam int DEPTH   = 8;
   localparam int ROWS    = 64;
   localparam int ENTRY_W = CNT_W + DATA_W;
   localparam logic [ADDR_W-1:0] ROW_STRIDE = 64'd256;

   // ---------------- clock / reset ----------------
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cmd_valid = 1'b0;
   logic [ADDR_W-1:0] cmd_addr = '0;
   logic              bot_valid = 1'b0;
   logic [CNT_W-1:0]  bot_cnt = '0;
   logic [DATA_W-1:0] bot_data = '0;
   logic              aw_ready = 1'b0;
   logic              cmd_ready_o;
   logic              aw_valid_o;
   logic [ADDR_W-1:0] aw_addr_o;
   logic [DATA_W-1:0] aw_data_o;
   logic              busy_o;
   logic              done_o;
   logic [1:0]        err_o;

   always #5 clk = ~clk;

   storec_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready_o),
      .cmd_addr_i  (cmd_addr),
      .bot_valid_i (bot_valid),
      .bot_cnt_i   (bot_cnt),
      .bot_data_i  (bot_data),
      .aw_valid_o  (aw_valid_o),
      .aw_ready_i  (aw_ready),
      .aw_addr_o   (aw_addr_o),
      .aw_data_o   (aw_data_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o)
   );

   // ---------------- check bookkeeping ----------------
   int checks_total  = 0;
   int checks_passed = 0;

   task automatic check(input string name, input logic [DATA_W-1:0] act,
                        input logic [DATA_W-1:0] exp);
      checks_total++;
      if (act === exp) checks_passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   // Rows waiting to be written, oldest first: {cnt, data}.
   logic [ENTRY_W-1:0] exp_q[$];
   bit                 m_active = 0;   // collecting rows for a STOREC
   bit                 m_done   = 0;   // completion cycle
   logic [ADDR_W-1:0]  m_base   = '0;
   int                 m_rx     = 0;
   logic [1:0]         m_err    = '0;

   bit                 started    = 0;
   bit                 done_seen  = 0;
   int                 done_cnt   = 0;
   int                 beat_cnt   = 0;
   logic [ADDR_W-1:0]  beat_log[$];
   bit                 prev_stall = 0;
   logic [ADDR_W-1:0]  prev_addr;
   logic [DATA_W-1:0]  prev_data;

   // One compare process: check outputs against the model, then advance it.
   always @(negedge clk) begin
      logic               byp;
      logic               exp_valid;
      logic [ENTRY_W-1:0] head;
      logic [CNT_W-1:0]   h_cnt;
      logic [ADDR_W-1:0]  exp_addr;
      bit                 was_active, was_done, was_empty, pop;
      int                 old_rx;
      if (started) begin
         byp = 1'b0;
`ifdef STOREC_WB_BYPASS_EN
         byp = m_active && (exp_q.size() == 0) && bot_valid;
`endif
         exp_valid = (exp_q.size() != 0) || byp;
         check("aw_valid", aw_valid_o, exp_valid);
         if (exp_valid) begin
            head     = byp ? {bot_cnt, bot_data} : exp_q[0];
            h_cnt    = head[ENTRY_W-1:DATA_W];
            exp_addr = m_base + ADDR_W'(h_cnt) * ROW_STRIDE;
            check("aw_addr", aw_addr_o, exp_addr);
            check("aw_data", aw_data_o, head[DATA_W-1:0]);
         end
         check("cmd_ready", cmd_ready_o, !m_active && !m_done);
         check("busy", busy_o, m_active || m_done);
         check("done", done_o, m_done);
         check("err", err_o, m_err);
         if (prev_stall) begin
            check("aw_hold_valid", aw_valid_o, 1'b1);
            check("aw_hold_addr", aw_addr_o, prev_addr);
            check("aw_hold_data", aw_data_o, prev_data);
         end
         prev_stall = aw_valid_o && !aw_ready && !rst;
         prev_addr  = aw_addr_o;
         prev_data  = aw_data_o;
         if (aw_valid_o && aw_ready && !rst) begin
            beat_cnt++;
            beat_log.push_back(aw_addr_o);
         end
         if (done_o) begin
            done_cnt++;
            done_seen = 1;
         end

         // Advance the model by one clock edge.
         if (rst) begin
            exp_q.delete();
            m_active = 0; m_done = 0; m_base = '0; m_rx = 0; m_err = '0;
         end else begin
            was_active = m_active;
            was_done   = m_done;
            was_empty  = (exp_q.size() == 0);
            old_rx     = m_rx;
            pop        = exp_valid && aw_ready;
            if (bot_valid && !was_active) m_err[1] = 1'b1;
            if (pop && !byp) void'(exp_q.pop_front());
            if (was_active) begin
               if (bot_valid) begin
                  m_rx++;
                  if (!(byp && aw_ready)) begin
                     if (exp_q.size() < DEPTH) exp_q.push_back({bot_cnt, bot_data});
                     else m_err[0] = 1'b1;
                  end
               end
               if (old_rx == ROWS && was_empty) begin
                  m_active = 0;
                  m_done   = 1;
               end
            end else if (was_done) begin
               m_done = 0;
            end else if (cmd_valid) begin
               m_active = 1; m_base = cmd_addr; m_rx = 0; m_err = '0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DATA_W-1:0] rand_data();
      logic [DATA_W-1:0] d;
      for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
      return d;
   endfunction

   task automatic start_op(input logic [ADDR_W-1:0] a);
      int n;
      n = 0;
      done_seen = 0;
      beat_log.delete();
      cmd_valid = 1'b1;
      cmd_addr  = a;
      while (!cmd_ready_o && n < 200) begin
         tick();
         n++;
      end
      tick();
      cmd_valid = 1'b0;
      check("cmd_accept_timeout", n < 200, 1'b1);
   endtask

   task automatic send_row(input logic [CNT_W-1:0] c, input logic [DATA_W-1:0] d,
                           input logic rdy);
      bot_valid = 1'b1;
      bot_cnt   = c;
      bot_data  = d;
      aw_ready  = rdy;
      tick();
      bot_valid = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int n;
      n = 0;
      aw_ready = 1'b1;
      while (!done_seen && n < budget) begin
         tick();
         n++;
      end
      check("done_timeout", done_seen, 1'b1);
      repeat (2) tick();
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d0, b0;
      int perm[ROWS];
      logic [ADDR_W-1:0] rbase;

      repeat (3) tick();
      started = 1;
      @(negedge clk);
      check("rst_cmd_ready", cmd_ready_o, 1'b1);
      check("rst_aw_valid", aw_valid_o, 1'b0);
      check("rst_busy", busy_o, 1'b0);
      check("rst_done", done_o, 1'b0);
      check("rst_err", err_o, 2'b00);
      tick();
      rst = 1'b0;
      tick();

      // Basic drain: 64 in-order rows, aw always ready.
      d0 = done_cnt;
      start_op(64'h1000);
      for (int c = 0; c < ROWS; c++) begin
         send_row(CNT_W'(c), rand_data(), 1'b1);
`ifndef STOREC_WB_BYPASS_EN
         if (c == 0) begin
            check("first_row_latency_valid", aw_valid_o, 1'b1);
            check("first_row_latency_addr", aw_addr_o, 64'h1000);
         end
`endif
      end
      wait_done(300);
      check("basic_beats", beat_log.size(), ROWS);
      if (beat_log.size() == ROWS) begin
         check("basic_first_addr", beat_log[0], 64'h1000);
         check("basic_last_addr", beat_log[ROWS-1], 64'h4F00);
      end
      check("basic_done_once", done_cnt - d0, 1);
      check("basic_err", err_o, 2'b00);

      // Backpressure: 8 rows while stalled, then drain.
      start_op(64'h20000);
      for (int c = 0; c < 8; c++) send_row(CNT_W'(c), rand_data(), 1'b0);
      check("bp_err_full", err_o, 2'b00);
      check("bp_head_addr", aw_addr_o, 64'h20000);
      for (int c = 8; c < ROWS; c++) send_row(CNT_W'(c), rand_data(), 1'b1);
      wait_done(300);
      check("bp_beats", beat_log.size(), ROWS);
      check("bp_err", err_o, 2'b00);

      // Overflow: 10 rows while stalled, rows 8 and 9 are lost.
      start_op(64'h40000);
      for (int c = 0; c < 10; c++) send_row(CNT_W'(c), rand_data(), 1'b0);
      check("ovf_err", err_o, 2'b01);
      for (int c = 10; c < ROWS; c++) send_row(CNT_W'(c), rand_data(), 1'b1);
      wait_done(300);
      check("ovf_beats", beat_log.size(), ROWS - 2);
      check("ovf_err_after", err_o, 2'b01);

      // Stray row in IDLE, then the next accept clears errors.
      b0 = beat_cnt;
      send_row(CNT_W'(5), rand_data(), 1'b1);
      tick();
      check("stray_err", err_o[1], 1'b1);
      check("stray_no_beat", beat_cnt - b0, 0);
      start_op(64'h80000);
      check("accept_clears_err", err_o, 2'b00);

      // Reset mid-drain with rows still buffered.
      d0 = done_cnt;
      for (int c = 0; c < 15; c++) send_row(CNT_W'(c), rand_data(), 1'b1);
      for (int c = 15; c < 20; c++) send_row(CNT_W'(c), rand_data(), 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_aw_valid", aw_valid_o, 1'b0);
      check("midrst_busy", busy_o, 1'b0);
      check("midrst_cmd_ready", cmd_ready_o, 1'b1);
      repeat (5) tick();
      check("midrst_no_done", done_cnt - d0, 0);

      // Address wrap at the top of the address space.
      start_op(64'hFFFF_FFFF_FFFF_FF00);
`ifdef STOREC_WB_BYPASS_EN
      bot_valid = 1'b1; bot_cnt = CNT_W'(1); bot_data = rand_data(); aw_ready = 1'b1;
      #1;
      check("bypass_same_cycle_valid", aw_valid_o, 1'b1);
      check("wrap_addr", aw_addr_o, 64'h0);
      tick();
      bot_valid = 1'b0;
`else
      send_row(CNT_W'(1), rand_data(), 1'b0);
      check("wrap_valid", aw_valid_o, 1'b1);
      check("wrap_addr", aw_addr_o, 64'h0);
`endif
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();

      // Randomized operations: shuffled row order, gaps and stalls.
      for (int op = 0; op < 4; op++) begin
         rbase = {$urandom, $urandom};
         for (int i = 0; i < ROWS; i++) perm[i] = i;
         for (int i = ROWS - 1; i > 0; i--) begin
            int j, t;
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
         end
         start_op(rbase);
         for (int i = 0; i < ROWS; i++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               aw_ready = ($urandom_range(0, 3) != 0);
               tick();
            end
            send_row(CNT_W'(perm[i]), rand_data(), ($urandom_range(0, 3) != 0));
         end
         wait_done(500);
      end

      repeat (3) tick();
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/storec_writeback.md
Name: storec_writeback

Overview:
- Downstream of the systolic-array top. Consumes the array's bottom-edge result rows (valid/cnt/data) during a STOREC operation and buffers them in a small FIFO.
- Drains the rows to memory over the aw write channel: one aw beat per row, address = base + (cnt << ROW_SHIFT).
- Signals completion once every expected row has been written.
- The array output has no ready, so this block must absorb bursts and flag any loss.

Parameters:
- ADDR_W, 64, address width (matches the codebase's ADDR_WIDTH).
- DATA_W, 512, row data width (matches SARRAY_STORE_WIDTH).
- CNT_W, 6, row-index width; a STOREC carries 2^CNT_W rows.
- FIFO_DEPTH, 8, row buffer entries; power of two, >=2.
- ROW_SHIFT, 8, byte-stride shift per row (same stride as the load path).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cmd_valid_i  in  1  STOREC command valid.
- cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
- cmd_addr_i  in  ADDR_W  destination base address.
- bot_valid_i  in  1  array bottom row valid; no backpressure.
- bot_cnt_i  in  CNT_W  row index of bot_data_i.
- bot_data_i  in  DATA_W  result row.
- aw_valid_o  out  1  write request valid.
- aw_ready_i  in  1  write request accepted.
- aw_addr_o  out  ADDR_W  write address.
- aw_data_o  out  DATA_W  write data.
- busy_o  out  1  high in DRAIN or DONE.
- done_o  out  1  one-cycle pulse, operation complete.
- err_o  out  2  sticky; bit0 = FIFO overflow drop, bit1 = stray row outside DRAIN.

Behaviour:
- Reset: state=IDLE, FIFO empty, rx_cnt=0, base=0, err=0. All outputs low/zero except cmd_ready_o=1.
- States:
  - IDLE: cmd_ready_o=1. On cmd handshake, latch base, clear rx_cnt and err, go to DRAIN.
  - DRAIN: cmd_ready_o=0. Each bot_valid_i is a push and increments rx_cnt (CNT_W+1 bits).
    - Exit to DONE when rx_cnt==2^CNT_W, FIFO empty and no aw beat outstanding.
  - DONE: done_o=1 for exactly one cycle, then IDLE.
- FIFO entry = {cnt, data}. aw_valid_o = FIFO non-empty.
  - aw_addr_o = base + (zero-extended head cnt << ROW_SHIFT), computed modulo 2^ADDR_W.
  - aw_data_o = head data. Pop on aw_valid_o & aw_ready_i.
- aw_valid_o, once high, holds with stable addr/data until the handshake (AXI-style; no retraction).
- Latency: a row pushed in cycle N is presented on aw in cycle N+1 (registered FIFO).
- Row order is FIFO order. Address comes from the row's own cnt, so out-of-order cnt is written correctly.
- Full + push + pop in the same cycle: push accepted, no error.
- Full + push without pop: row dropped, err_o[0] set, rx_cnt still increments so the operation cannot hang.
- bot_valid_i in IDLE or DONE: row ignored, err_o[1] set, rx_cnt unchanged.
- Pointer wrap: read/write pointers are log2(FIFO_DEPTH)+1 bits; full/empty come from MSB compare.
- Reset mid-operation: all state returns to reset values within one cycle; FIFO contents are discarded; no done_o pulse.
- cmd_valid_i while busy: not accepted; the command is held by the issuer.

Optional Feature:
- Macro STOREC_WB_BYPASS_EN.
  - Defined: when in DRAIN, FIFO empty and bot_valid_i high, the row drives aw combinationally in the same cycle. If aw_ready_i is also high the row completes without entering the FIFO (0-cycle latency); otherwise it is pushed and held.
  - Undefined: always 1-cycle latency through the FIFO; aw outputs are purely registered.

Decomposition:
- Shared package/defines header:
  - state encoding (IDLE/DRAIN/DONE)
  - err bit indices
  - default ROW_SHIFT
  - reuse of ADDR_WIDTH, SARRAY_STORE_WIDTH, TMMA_CNT_WIDTH.
- One sub-module: storec_row_fifo, a synchronous FIFO with push/pop/full/empty, width CNT_W+DATA_W, depth FIFO_DEPTH.

Test Plan:
- Basic drain: cmd base=0x1000; 64 rows cnt 0..63 back-to-back, aw_ready_i=1 → 64 aw beats at addresses 0x1000..0x4F00, step 0x100, data in order; done_o pulses once; err_o=0.
- Backpressure: aw_ready_i low for 8 cycles while 8 rows arrive, then high → no drop; addresses and data held stable while stalled; err_o=0.
- Overflow: aw_ready_i low, 10 rows pushed with FIFO_DEPTH=8 → rows 8 and 9 dropped, err_o[0]=1; remaining 54 rows plus 8 buffered complete; done_o fires.
- Stray row: bot_valid_i pulse in IDLE → err_o[1]=1, no aw beat. The next cmd accept clears err_o.
- Reset mid-DRAIN after 20 rows with 5 buffered → aw_valid_o=0, busy_o=0, cmd_ready_o=1 on the next cycle; no done_o.
- Address wrap: base=0xFFFF_FFFF_FFFF_FF00, cnt=1 → aw_addr_o=0x0; bypass build with empty FIFO and aw_ready_i=1 → aw_valid_o in the same cycle as bot_valid_i.
